// File: rtl/obc1_bus_xlat.sv
// obc1_bus_xlat: OBC1 register view in front of the SaveRAM for the SNES
// $7800-$7FFF window. Turns SNES read/write strobes into SRAM requests,
// remaps $7FF0-$7FF4 through the base/index shadow registers, and does
// $7FF4 two-bit writes as a read-modify-write. A one-entry pending slot
// absorbs a strobe that arrives while a transaction is in flight.
//
// Optional feature: define OBC1_SHADOW_READ_EN to answer reads of $7FF5
// and $7FF6 straight from the shadow registers without touching SRAM.
//
// SRAM handshake: RAM_RD_REQ / RAM_WR_REQ are levels driven from the
// registered state. Once raised, a request and its RAM_ADDR / RAM_WDATA
// hold unchanged until the cycle on which RAM_ACK is sampled high; that
// ACK completes exactly one request and the request drops the next cycle.
// An ACK sampled while no request is up is ignored.
module obc1_bus_xlat #(
    parameter logic [12:0] BASE_HI = 13'h1C00,
    parameter logic [12:0] BASE_LO = 13'h1800
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable,
    input  logic [12:0] SNES_ADDR,
    input  logic [7:0]  SNES_DATA_IN,
    input  logic        reg_rd_start,
    input  logic        reg_wr_end,
    output logic [7:0]  SNES_DATA_OUT,
    output logic [12:0] RAM_ADDR,
    output logic        RAM_RD_REQ,
    output logic        RAM_WR_REQ,
    output logic [7:0]  RAM_WDATA,
    input  logic [7:0]  RAM_RDATA,
    input  logic        RAM_ACK,
    output logic        busy,
    output logic        overflow,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_WR     = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_base_sel, w_base_sel_nxt;
    logic [6:0]  r_index, w_index_nxt;
    logic        r_pend_vld, w_pend_vld_nxt;
    logic        r_pend_wr, w_pend_wr_nxt;
    logic [12:0] r_pend_addr, w_pend_addr_nxt;
    logic [7:0]  r_pend_data, w_pend_data_nxt;
    logic        r_overflow, w_overflow_nxt;
    logic [12:0] r_ram_addr, w_ram_addr_nxt;
    logic [7:0]  r_ram_wdata, w_ram_wdata_nxt;
    logic [7:0]  r_data_out, w_data_out_nxt;
    logic [1:0]  r_rmw_bits, w_rmw_bits_nxt;
    logic [2:0]  r_rmw_shift, w_rmw_shift_nxt;

    logic        w_wr_stb, w_rd_stb;
    logic        w_first_vld, w_first_wr, w_second_vld;
    logic        w_go, w_go_wr;
    logic [12:0] w_go_addr;
    logic [7:0]  w_go_data;
    logic [12:0] w_base, w_xaddr;
    logic [2:0]  w_xshift;

    // Incoming strobes in service order: the write goes first, a
    // simultaneous read is second in line.
    assign w_wr_stb     = enable & reg_wr_end;
    assign w_rd_stb     = enable & reg_rd_start;
    assign w_first_vld  = w_wr_stb | w_rd_stb;
    assign w_first_wr   = w_wr_stb;
    assign w_second_vld = w_wr_stb & w_rd_stb;

    // Pick the access to launch this cycle and decide what lands in the pending slot or is dropped.
    always_comb begin
        w_go            = 1'b0;
        w_go_wr         = 1'b0;
        w_go_addr       = SNES_ADDR;
        w_go_data       = SNES_DATA_IN;
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_wr_nxt   = r_pend_wr;
        w_pend_addr_nxt = r_pend_addr;
        w_pend_data_nxt = r_pend_data;
        w_overflow_nxt  = r_overflow;
        if (r_state == S_IDLE && r_pend_vld) begin
            // The parked access goes out; the slot is free again for the first new strobe.
            w_go            = 1'b1;
            w_go_wr         = r_pend_wr;
            w_go_addr       = r_pend_addr;
            w_go_data       = r_pend_data;
            w_pend_vld_nxt  = w_first_vld;
            w_pend_wr_nxt   = w_first_wr;
            w_pend_addr_nxt = SNES_ADDR;
            w_pend_data_nxt = SNES_DATA_IN;
            if (w_second_vld) begin
                w_overflow_nxt = 1'b1;
            end
        end else if (r_state == S_IDLE) begin
            w_go            = w_first_vld;
            w_go_wr         = w_first_wr;
            w_pend_vld_nxt  = w_second_vld;
            w_pend_wr_nxt   = 1'b0;
            w_pend_addr_nxt = SNES_ADDR;
            w_pend_data_nxt = SNES_DATA_IN;
        end else if (r_pend_vld) begin
            if (w_first_vld) begin
                w_overflow_nxt = 1'b1;
            end
        end else begin
            w_pend_vld_nxt  = w_first_vld;
            w_pend_wr_nxt   = w_first_wr;
            w_pend_addr_nxt = SNES_ADDR;
            w_pend_data_nxt = SNES_DATA_IN;
            if (w_second_vld) begin
                w_overflow_nxt = 1'b1;
            end
        end
    end

    // Translate the launching address through the current base/index shadows.
    always_comb begin
        w_base   = r_base_sel ? BASE_LO : BASE_HI;
        w_xaddr  = w_go_addr;
        w_xshift = 3'd0;
        if (w_go_addr[12:2] == 11'h7FC) begin
            w_xaddr = w_base + {4'b0000, r_index, 2'b00} + {11'b0, w_go_addr[1:0]};
        end else if (w_go_addr == 13'h1FF4) begin
            w_xaddr  = w_base + 13'h0200 + {8'b0, r_index[6:2]};
            w_xshift = {r_index[1:0], 1'b0};
        end
    end

    // FSM next state plus the registered SRAM/SNES side values.
    always_comb begin
        w_state_nxt     = r_state;
        w_base_sel_nxt  = r_base_sel;
        w_index_nxt     = r_index;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_wdata_nxt = r_ram_wdata;
        w_data_out_nxt  = r_data_out;
        w_rmw_bits_nxt  = r_rmw_bits;
        w_rmw_shift_nxt = r_rmw_shift;

        case (r_state)
            S_RD: begin
                if (RAM_ACK) begin
                    w_data_out_nxt = RAM_RDATA;
                    w_state_nxt    = S_IDLE;
                end
            end
            S_WR: begin
                if (RAM_ACK) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RMW_RD: begin
                if (RAM_ACK) begin
                    w_ram_wdata_nxt = (RAM_RDATA & ~(8'h03 << r_rmw_shift))
                                    | ({6'b0, r_rmw_bits} << r_rmw_shift);
                    w_state_nxt     = S_RMW_WR;
                end
            end
            S_RMW_WR: begin
                if (RAM_ACK) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: ;
        endcase

        // w_go is only ever raised from IDLE, so it never collides with the case above.
        if (w_go) begin
            if (w_go_wr) begin
                if (w_go_addr == 13'h1FF5) begin
                    w_base_sel_nxt = w_go_data[0];
                end
                if (w_go_addr == 13'h1FF6) begin
                    w_index_nxt = w_go_data[6:0];
                end
                w_ram_addr_nxt  = w_xaddr;
                w_ram_wdata_nxt = w_go_data;
                if (w_go_addr == 13'h1FF4) begin
                    w_rmw_bits_nxt  = w_go_data[1:0];
                    w_rmw_shift_nxt = w_xshift;
                    w_state_nxt     = S_RMW_RD;
                end else begin
                    w_state_nxt = S_WR;
                end
            end else begin
`ifdef OBC1_SHADOW_READ_EN
                if (w_go_addr == 13'h1FF5) begin
                    w_data_out_nxt = {7'b0, r_base_sel};
                end else if (w_go_addr == 13'h1FF6) begin
                    w_data_out_nxt = {1'b0, r_index};
                end else begin
                    w_ram_addr_nxt = w_xaddr;
                    w_state_nxt    = S_RD;
                end
`else
                w_ram_addr_nxt = w_xaddr;
                w_state_nxt    = S_RD;
`endif
            end
        end
    end

    // State and datapath registers; reset drops everything including a request in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_base_sel  <= 1'b0;
            r_index     <= 7'd0;
            r_pend_vld  <= 1'b0;
            r_pend_wr   <= 1'b0;
            r_pend_addr <= 13'd0;
            r_pend_data <= 8'd0;
            r_overflow  <= 1'b0;
            r_ram_addr  <= 13'd0;
            r_ram_wdata <= 8'd0;
            r_data_out  <= 8'd0;
            r_rmw_bits  <= 2'd0;
            r_rmw_shift <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_base_sel  <= w_base_sel_nxt;
            r_index     <= w_index_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_wr   <= w_pend_wr_nxt;
            r_pend_addr <= w_pend_addr_nxt;
            r_pend_data <= w_pend_data_nxt;
            r_overflow  <= w_overflow_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_data_out  <= w_data_out_nxt;
            r_rmw_bits  <= w_rmw_bits_nxt;
            r_rmw_shift <= w_rmw_shift_nxt;
        end
    end

    assign RAM_RD_REQ    = (r_state == S_RD) || (r_state == S_RMW_RD);
    assign RAM_WR_REQ    = (r_state == S_WR) || (r_state == S_RMW_WR);
    assign RAM_ADDR      = r_ram_addr;
    assign RAM_WDATA     = r_ram_wdata;
    assign SNES_DATA_OUT = r_data_out;
    assign busy          = (r_state != S_IDLE);
    assign overflow      = r_overflow;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_obc1_bus_xlat.sv
// Bench for obc1_bus_xlat: directed scenarios with literal expectations,
// then randomized strobes/ACKs checked every cycle against a queue-based
// transaction model and an SRAM-transfer scoreboard.
module tb_obc1_bus_xlat;

`ifdef OBC1_SHADOW_READ_EN
    localparam bit SHADOW_RD = 1'b1;
`else
    localparam bit SHADOW_RD = 1'b0;
`endif

    logic        CLK, RST, enable, reg_rd_start, reg_wr_end, RAM_ACK;
    logic [12:0] SNES_ADDR;
    logic [7:0]  SNES_DATA_IN, RAM_RDATA;
    logic [7:0]  SNES_DATA_OUT, RAM_WDATA;
    logic [12:0] RAM_ADDR;
    logic        RAM_RD_REQ, RAM_WR_REQ, busy, overflow;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    obc1_bus_xlat dut (
        .CLK(CLK), .RST(RST), .enable(enable), .SNES_ADDR(SNES_ADDR),
        .SNES_DATA_IN(SNES_DATA_IN), .reg_rd_start(reg_rd_start), .reg_wr_end(reg_wr_end),
        .SNES_DATA_OUT(SNES_DATA_OUT), .RAM_ADDR(RAM_ADDR), .RAM_RD_REQ(RAM_RD_REQ),
        .RAM_WR_REQ(RAM_WR_REQ), .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA),
        .RAM_ACK(RAM_ACK), .busy(busy), .overflow(overflow), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- SRAM responder ----------------
    // ack_mode: 0 ack at once, 1 random (with stray ACKs), 2 stall, 3 ack once then stall
    int          ack_mode  = 0;
    bit          force_ack = 1'b0;
    logic [7:0]  rdata_val = 8'h00;

    always @(negedge CLK) begin
        bit req;
        req = RAM_RD_REQ || RAM_WR_REQ;
        RAM_RDATA = rdata_val;
        case (ack_mode)
            0: RAM_ACK = req;
            1: begin
                RAM_ACK   = req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
                RAM_RDATA = 8'($urandom);
            end
            3: begin
                RAM_ACK = req;
                if (req) ack_mode = 2;
            end
            default: RAM_ACK = 1'b0;
        endcase
        if (force_ack) RAM_ACK = 1'b1;
    end

    // ---------------- behavioural model ----------------
    // Accesses accepted by the block wait in m_q (front = the one in service
    // when m_active). At most two may be held: one in service, one waiting.
    typedef struct {
        bit          wr;
        logic [12:0] a;
        logic [7:0]  d;
    } acc_t;

    acc_t        m_q[$];
    bit          m_active, m_is_rmw, m_rmw_second;
    logic [12:0] m_addr;
    logic [7:0]  m_wdata, m_dout;
    bit          m_base_sel, m_ovf;
    logic [6:0]  m_index;
    int          m_shift;
    logic [1:0]  m_bits;
    logic [21:0] exp_q[$];
    logic [12:0] last_ack_addr;

    function automatic logic [12:0] m_xlat(input logic [12:0] a);
        int base, r;
        base = m_base_sel ? 'h1800 : 'h1C00;
        if (a >= 13'h1FF0 && a <= 13'h1FF3) r = base + int'(m_index) * 4 + int'(a) % 4;
        else if (a == 13'h1FF4)             r = base + 'h200 + int'(m_index) / 4;
        else                                r = int'(a);
        return 13'(r % 8192);
    endfunction

    function automatic logic [7:0] m_merge(input logic [7:0] old, input int sh, input logic [1:0] b);
        int v;
        v = (int'(old) & ~(3 << sh) & 255) | (int'(b) << sh);
        return 8'(v);
    endfunction

    task automatic m_accept(input bit wr, input logic [12:0] a, input logic [7:0] d);
        acc_t e;
        e.wr = wr; e.a = a; e.d = d;
        if (m_q.size() < 2) m_q.push_back(e);
        else m_ovf = 1'b1;
    endtask

    task automatic m_launch();
        acc_t e;
        e = m_q[0];
        if (e.wr) begin
            m_addr = m_xlat(e.a);
            if (e.a == 13'h1FF4) begin
                m_is_rmw = 1'b1; m_rmw_second = 1'b0;
                m_shift  = (int'(m_index) % 4) * 2;
                m_bits   = e.d[1:0];
                exp_q.push_back({1'b0, m_addr, 8'h00});
            end else begin
                m_is_rmw = 1'b0;
                m_wdata  = e.d;
                exp_q.push_back({1'b1, m_addr, e.d});
            end
            if (e.a == 13'h1FF5) m_base_sel = e.d[0];
            if (e.a == 13'h1FF6) m_index = e.d[6:0];
            m_active = 1'b1;
        end else if (SHADOW_RD && (e.a == 13'h1FF5 || e.a == 13'h1FF6)) begin
            m_dout = (e.a == 13'h1FF5) ? {7'b0, m_base_sel} : {1'b0, m_index};
            void'(m_q.pop_front());
        end else begin
            m_addr   = m_xlat(e.a);
            m_is_rmw = 1'b0;
            m_active = 1'b1;
            exp_q.push_back({1'b0, m_addr, 8'h00});
        end
    endtask

    task automatic m_step();
        bit was_active;
        if (RST) begin
            m_q.delete(); exp_q.delete();
            m_active = 0; m_is_rmw = 0; m_rmw_second = 0;
            m_addr = 0; m_wdata = 0; m_dout = 0;
            m_base_sel = 0; m_index = 0; m_ovf = 0;
            return;
        end
        was_active = m_active;
        if (enable && reg_wr_end)   m_accept(1'b1, SNES_ADDR, SNES_DATA_IN);
        if (enable && reg_rd_start) m_accept(1'b0, SNES_ADDR, SNES_DATA_IN);
        if (was_active) begin
            if (RAM_ACK) begin
                if (!m_q[0].wr) begin
                    m_dout = RAM_RDATA;
                    m_active = 0; void'(m_q.pop_front());
                end else if (m_is_rmw && !m_rmw_second) begin
                    m_wdata = m_merge(RAM_RDATA, m_shift, m_bits);
                    m_rmw_second = 1'b1;
                    exp_q.push_back({1'b1, m_addr, m_wdata});
                end else begin
                    m_active = 0; void'(m_q.pop_front());
                end
            end
        end else if (m_q.size() > 0) begin
            m_launch();
        end
    endtask

    // ---------------- scoreboard + per-cycle compare ----------------
    always @(posedge CLK) begin
        bit exp_rd, exp_wr;
        logic [21:0] obs;
        if ((RAM_RD_REQ || RAM_WR_REQ) && RAM_ACK) begin
            obs = {RAM_WR_REQ, RAM_ADDR, RAM_WR_REQ ? RAM_WDATA : 8'h00};
            last_ack_addr = RAM_ADDR;
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL sb_xfer: unexpected transfer 0x%0h expected none at %0t", obs, $time);
            end else begin
                check("sb_xfer", obs, exp_q.pop_front());
            end
        end
        m_step();
        #1;
        exp_rd = m_active && (!m_q[0].wr || (m_is_rmw && !m_rmw_second));
        exp_wr = m_active && !exp_rd;
        check("dout", SNES_DATA_OUT, m_dout);
        check("busy", busy, m_active);
        check("overflow", overflow, m_ovf);
        check("rd_req", RAM_RD_REQ, exp_rd);
        check("wr_req", RAM_WR_REQ, exp_wr);
        if (exp_rd || exp_wr) check("ram_addr", RAM_ADDR, m_addr);
        if (exp_wr) check("ram_wdata", RAM_WDATA, m_wdata);
    end

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; the strobe is seen by the next rising edge.
    task automatic strobe(input bit wr, input bit rd, input bit en,
                          input logic [12:0] a, input logic [7:0] d);
        enable = en; SNES_ADDR = a; SNES_DATA_IN = d;
        reg_wr_end = wr; reg_rd_start = rd;
        @(negedge CLK);
        reg_wr_end = 1'b0; reg_rd_start = 1'b0; enable = 1'b1;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            if (m_q.size() == 0 && !m_active) done = 1'b1;
            else @(negedge CLK);
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles", max_cyc);
        end
    endtask

    task automatic write_reg(input logic [12:0] a, input logic [7:0] d);
        strobe(1'b1, 1'b0, 1'b1, a, d);
        wait_idle(50);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST = 1'b1; enable = 1'b1; reg_rd_start = 1'b0; reg_wr_end = 1'b0;
        SNES_ADDR = '0; SNES_DATA_IN = '0; RAM_ACK = 1'b0; RAM_RDATA = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check("rst_dout", SNES_DATA_OUT, 8'h00);
        check("rst_addr", RAM_ADDR, 13'h0000);
        check("rst_wdata", RAM_WDATA, 8'h00);
        check("rst_reqs", {RAM_RD_REQ, RAM_WR_REQ, busy, overflow}, 4'b0000);
        check("rst_state_idle", dbg_state, 3'd0);

        // Base select LO, index 5, read $7FF2 -> 0x1800 + 0x14 + 2.
        write_reg(13'h1FF5, 8'h01);
        write_reg(13'h1FF6, 8'h05);
        rdata_val = 8'hA5;
        strobe(1'b0, 1'b1, 1'b1, 13'h1FF2, 8'h00);
        check("t1_addr", RAM_ADDR, 13'h1816);
        check("t1_rd_req", RAM_RD_REQ, 1'b1);
        @(negedge CLK);
        check("t1_dout", SNES_DATA_OUT, 8'hA5);

        // Index 7, base HI, 2-bit write of 2 at shift 6 into 0xFF -> 0xBF at 0x1E01.
        write_reg(13'h1FF5, 8'h00);
        write_reg(13'h1FF6, 8'h07);
        rdata_val = 8'hFF;
        strobe(1'b1, 1'b0, 1'b1, 13'h1FF4, 8'h02);
        check("t2_rmw_rd_addr", RAM_ADDR, 13'h1E01);
        check("t2_rmw_rd_req", {RAM_RD_REQ, RAM_WR_REQ}, 2'b10);
        @(negedge CLK);
        check("t2_rmw_wr_req", {RAM_RD_REQ, RAM_WR_REQ}, 2'b01);
        check("t2_rmw_wr_addr", RAM_ADDR, 13'h1E01);
        check("t2_rmw_wdata", RAM_WDATA, 8'hBF);
        wait_idle(20);

        // Pass-through, then the same read with enable low.
        strobe(1'b0, 1'b1, 1'b1, 13'h1234, 8'h00);
        check("t3_pass_addr", RAM_ADDR, 13'h1234);
        check("t3_pass_req", RAM_RD_REQ, 1'b1);
        wait_idle(20);
        strobe(1'b0, 1'b1, 1'b0, 13'h1234, 8'h00);
        check("t3_dis_req", {RAM_RD_REQ, busy}, 2'b00);

        // Three strobes under a stalled SRAM: one served, one parked, one dropped.
        ack_mode = 2;
        strobe(1'b0, 1'b1, 1'b1, 13'h0100, 8'h00);
        strobe(1'b0, 1'b1, 1'b1, 13'h0101, 8'h00);
        strobe(1'b0, 1'b1, 1'b1, 13'h0102, 8'h00);
        check("t4_overflow", overflow, 1'b1);
        check("t4_first_addr", RAM_ADDR, 13'h0100);
        ack_mode = 0;
        wait_idle(50);
        check("t4_second_served", last_ack_addr, 13'h0101);
        check("t4_overflow_sticky", overflow, 1'b1);

        // Reset in the middle of the RMW write phase.
        write_reg(13'h1FF5, 8'h01);
        write_reg(13'h1FF6, 8'h07);
        ack_mode = 3;
        strobe(1'b1, 1'b0, 1'b1, 13'h1FF4, 8'h03);
        check("t5_rmw_rd", RAM_RD_REQ, 1'b1);
        @(negedge CLK);
        check("t5_rmw_wr", RAM_WR_REQ, 1'b1);
        RST = 1'b1; force_ack = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("t5_rst_reqs", {RAM_RD_REQ, RAM_WR_REQ, busy, overflow}, 4'b0000);
        check("t5_rst_addr", RAM_ADDR, 13'h0000);
        check("t5_rst_dout", SNES_DATA_OUT, 8'h00);
        @(negedge CLK);
        force_ack = 1'b0; ack_mode = 0;
        check("t5_late_ack", {RAM_RD_REQ, RAM_WR_REQ, busy}, 3'b000);
        strobe(1'b0, 1'b1, 1'b1, 13'h1FF0, 8'h00);
        check("t5_shadow_cleared", RAM_ADDR, 13'h1C00);
        wait_idle(20);

`ifdef OBC1_SHADOW_READ_EN
        write_reg(13'h1FF6, 8'h55);
        strobe(1'b0, 1'b1, 1'b1, 13'h1FF6, 8'h00);
        check("t6_shadow_dout", SNES_DATA_OUT, 8'h55);
        check("t6_shadow_noreq", {RAM_RD_REQ, RAM_WR_REQ, busy}, 3'b000);
`endif

        // Randomized traffic against the model.
        ack_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            RST          = ($urandom_range(0, 399) == 0);
            enable       = ($urandom_range(0, 7) != 0);
            reg_wr_end   = ($urandom_range(0, 5) == 0);
            reg_rd_start = ($urandom_range(0, 5) == 0);
            SNES_ADDR    = ($urandom_range(0, 9) < 6) ? 13'(13'h1FF0 + $urandom_range(0, 6))
                                                      : 13'($urandom);
            SNES_DATA_IN = 8'($urandom);
            @(negedge CLK);
        end
        RST = 1'b0; reg_wr_end = 1'b0; reg_rd_start = 1'b0; enable = 1'b1;
        ack_mode = 0;
        wait_idle(100);
        @(negedge CLK);
        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
